// File: rtl/pong_engine.sv
// pong_engine: single-clock pong game state (paddles, ball, scores, match state) driven by
// tick enables. Define PONG_SPEEDUP_EN to speed the ball up on every paddle hit.
module pong_engine #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned COORD_W     = 11,
   parameter int unsigned PADDLE_H    = 60,
   parameter int unsigned PADDLE_STEP = 5,
   parameter int unsigned BALL_SIZE   = 6,
   parameter int unsigned PADDLE_X_L  = 20,
   parameter int unsigned PADDLE_X_R  = 610,
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned MAX_SPEED   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ball_tick,
   input  logic               pdl_tick,
   input  logic               p1_up,
   input  logic               p1_down,
   input  logic               p2_up,
   input  logic               p2_down,
   input  logic               new_game,
   output logic [COORD_W-1:0] pdl1_y,
   output logic [COORD_W-1:0] pdl2_y,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over,
   output logic               winner,
   output logic               hit,
   output logic               miss
);

   localparam int unsigned AW = COORD_W + 1;

   localparam logic [COORD_W-1:0] CX   = COORD_W'(H_ACTIVE / 2 - BALL_SIZE / 2);
   localparam logic [COORD_W-1:0] CY   = COORD_W'(V_ACTIVE / 2 - BALL_SIZE / 2);
   localparam logic [COORD_W-1:0] PMID = COORD_W'((V_ACTIVE - PADDLE_H) / 2);

   localparam logic [AW-1:0] PMAX = AW'(V_ACTIVE - PADDLE_H);
   localparam logic [AW-1:0] BMAX = AW'(V_ACTIVE - BALL_SIZE);
   localparam logic [AW-1:0] STEP = AW'(PADDLE_STEP);
   localparam logic [AW-1:0] BS1  = AW'(BALL_SIZE - 1);
   localparam logic [AW-1:0] PH1  = AW'(PADDLE_H - 1);
   localparam logic [AW-1:0] PXL  = AW'(PADDLE_X_L);
   localparam logic [AW-1:0] PXR  = AW'(PADDLE_X_R);
   localparam logic [AW-1:0] ONE  = AW'(1);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   localparam logic [1:0] StServe = 2'd0;
   localparam logic [1:0] StPlay  = 2'd1;
   localparam logic [1:0] StOver  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [COORD_W-1:0] pdl1_y_q, pdl1_y_d, pdl2_y_q, pdl2_y_d;
   logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
   logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [1:0]         serve_cnt_q, serve_cnt_d;
   logic               game_over_q, game_over_d, winner_q, winner_d;
   logic               hit_q, hit_d, miss_q, miss_d;
   logic [AW-1:0]      spd;

`ifdef PONG_SPEEDUP_EN
   localparam logic [AW-1:0] SMAX = AW'(MAX_SPEED);
   logic [AW-1:0] spd_q, spd_d;
   assign spd = spd_q;
`else
   assign spd = ONE;
`endif

   function automatic logic [COORD_W-1:0] pdl_next(input logic [COORD_W-1:0] y,
                                                   input logic up, input logic down);
      logic [AW-1:0] ye;
      ye = {1'b0, y};
      if (up && !down) begin
         ye = (ye >= STEP) ? ye - STEP : '0;
      end else if (down && !up) begin
         ye = (ye + STEP <= PMAX) ? ye + STEP : PMAX;
      end
      return ye[COORD_W-1:0];
   endfunction

   logic [AW-1:0] bx, by, p1e, p2e, bx_n, by_n;
   logic          ovl1, ovl2, scored;

   assign bx   = {1'b0, ball_x_q};
   assign by   = {1'b0, ball_y_q};
   assign p1e  = {1'b0, pdl1_y_q};
   assign p2e  = {1'b0, pdl2_y_q};
   assign ovl1 = (by + BS1 >= p1e) && (by <= p1e + PH1);
   assign ovl2 = (by + BS1 >= p2e) && (by <= p2e + PH1);

   always_comb begin
      state_d     = state_q;
      pdl1_y_d    = pdl1_y_q;
      pdl2_y_d    = pdl2_y_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      serve_cnt_d = serve_cnt_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      bx_n        = bx;
      by_n        = by;
      scored      = 1'b0;
`ifdef PONG_SPEEDUP_EN
      spd_d       = spd_q;
`endif
      if (new_game) begin
         state_d     = StServe;
         pdl1_y_d    = PMID;
         pdl2_y_d    = PMID;
         score1_d    = '0;
         score2_d    = '0;
         serve_cnt_d = '0;
         game_over_d = 1'b0;
         bx_n        = {1'b0, CX};
         by_n        = {1'b0, CY};
`ifdef PONG_SPEEDUP_EN
         spd_d       = ONE;
`endif
      end else if (state_q != StOver) begin
         if (pdl_tick) begin
            pdl1_y_d = pdl_next(pdl1_y_q, p1_up, p1_down);
            pdl2_y_d = pdl_next(pdl2_y_q, p2_up, p2_down);
         end
         if (ball_tick && state_q == StServe) begin
            dir_x_d     = serve_cnt_q[0];
            dir_y_d     = serve_cnt_q[1];
            serve_cnt_d = serve_cnt_q + 2'd1;
            state_d     = StPlay;
`ifdef PONG_SPEEDUP_EN
            spd_d       = ONE;
`endif
         end else if (ball_tick) begin
            // Walls reflect without moving; the ball resumes on the next tick.
            if (!dir_y_q) begin
               if (by < spd) dir_y_d = 1'b1;
               else          by_n    = by - spd;
            end else begin
               if (by + spd > BMAX) dir_y_d = 1'b0;
               else                 by_n    = by + spd;
            end
            if (!dir_x_q && bx < PXL + spd) begin
               if (ovl1) begin
                  dir_x_d = 1'b1;
                  hit_d   = 1'b1;
               end else begin
                  scored   = 1'b1;
                  score2_d = score2_q + SCORE_W'(1);
                  if (score2_d == WIN) winner_d = 1'b1;
               end
            end else if (dir_x_q && bx + BS1 + spd > PXR) begin
               if (ovl2) begin
                  dir_x_d = 1'b0;
                  hit_d   = 1'b1;
               end else begin
                  scored   = 1'b1;
                  score1_d = score1_q + SCORE_W'(1);
                  if (score1_d == WIN) winner_d = 1'b0;
               end
            end else begin
               bx_n = dir_x_q ? bx + spd : bx - spd;
            end
            if (scored) begin
               miss_d  = 1'b1;
               dir_y_d = dir_y_q;
               bx_n    = {1'b0, CX};
               by_n    = {1'b0, CY};
               if (score1_d == WIN || score2_d == WIN) begin
                  state_d     = StOver;
                  game_over_d = 1'b1;
               end else begin
                  state_d = StServe;
               end
            end
`ifdef PONG_SPEEDUP_EN
            if (hit_d && spd_q < SMAX) spd_d = spd_q + ONE;
`endif
         end
      end
      ball_x_d = bx_n[COORD_W-1:0];
      ball_y_d = by_n[COORD_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StServe;
         pdl1_y_q    <= PMID;
         pdl2_y_q    <= PMID;
         ball_x_q    <= CX;
         ball_y_q    <= CY;
         score1_q    <= '0;
         score2_q    <= '0;
         dir_x_q     <= 1'b0;
         dir_y_q     <= 1'b0;
         serve_cnt_q <= '0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pdl1_y_q    <= pdl1_y_d;
         pdl2_y_q    <= pdl2_y_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         serve_cnt_q <= serve_cnt_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

`ifdef PONG_SPEEDUP_EN
   always_ff @(posedge clk) begin
      if (rst) spd_q <= ONE;
      else     spd_q <= spd_d;
   end
`endif

   assign pdl1_y    = pdl1_y_q;
   assign pdl2_y    = pdl2_y_q;
   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign score1    = score1_q;
   assign score2    = score2_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign hit       = hit_q;
   assign miss      = miss_q;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: vector table, directed paddle/hit/miss sequences and
// randomized play against a behavioural model of the game rules.
module tb_pong_engine;

   localparam int CW   = 11;
   localparam int SW   = 4;
   localparam int WINS = 3;
   localparam int MAXS = 4;
   localparam int PH   = 60;
   localparam int BS   = 6;
   localparam int PXL  = 20;
   localparam int PXR  = 610;
   localparam int STEP = 5;
   localparam int PMAX = 420;
   localparam int BMAX = 474;
   localparam int CX   = 317;
   localparam int CY   = 237;

   logic clk = 1'b0;
   logic rst, ball_tick, pdl_tick, p1_up, p1_down, p2_up, p2_down, new_game;
   logic [CW-1:0] pdl1_y, pdl2_y, ball_x, ball_y;
   logic [SW-1:0] score1, score2;
   logic game_over, winner, hit, miss;

   pong_engine #(
      .WIN_SCORE (WINS),
      .MAX_SPEED (MAXS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ball_tick (ball_tick),
      .pdl_tick  (pdl_tick),
      .p1_up     (p1_up),
      .p1_down   (p1_down),
      .p2_up     (p2_up),
      .p2_down   (p2_down),
      .new_game  (new_game),
      .pdl1_y    (pdl1_y),
      .pdl2_y    (pdl2_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .score1    (score1),
      .score2    (score2),
      .game_over (game_over),
      .winner    (winner),
      .hit       (hit),
      .miss      (miss)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: ball velocity as signed +/-1 direction times speed.
   int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_phase, m_serve, m_spd;
   int m_win, m_go, m_hit, m_miss, n_hits, n_miss, n_over;

   function automatic int pmove(input int y, input logic up, input logic dn);
      int r;
      r = y;
      if (up && !dn) r = y - STEP;
      if (dn && !up) r = y + STEP;
      if (r < 0) r = 0;
      if (r > PMAX) r = PMAX;
      return r;
   endfunction

   function automatic bit overlaps(input int by, input int py);
      return (by <= py + PH - 1) && (py <= by + BS - 1);
   endfunction

   task automatic model_new_game();
      m_p1 = PMAX / 2; m_p2 = PMAX / 2; m_bx = CX; m_by = CY;
      m_s1 = 0; m_s2 = 0; m_go = 0; m_phase = 0; m_serve = 0; m_spd = 1;
   endtask

   task automatic model_step(input logic bt, input logic pt, input logic a, input logic b,
                             input logic c, input logic d, input logic ng, input logic r);
      int op1, op2, nx, ny;
      bit scored;
      m_hit = 0; m_miss = 0;
      op1 = m_p1; op2 = m_p2;
      if (r) begin
         model_new_game();
         m_win = 0; m_dx = -1; m_dy = -1;
      end else if (ng) begin
         model_new_game();
      end else if (m_phase != 2) begin
         if (pt) begin
            m_p1 = pmove(m_p1, a, b);
            m_p2 = pmove(m_p2, c, d);
         end
         if (bt && m_phase == 0) begin
            m_dx = m_serve[0] ? 1 : -1;
            m_dy = m_serve[1] ? 1 : -1;
            m_serve = (m_serve + 1) % 4;
            m_spd = 1;
            m_phase = 1;
         end else if (bt) begin
            scored = 0;
            ny = m_by + m_dy * m_spd;
            if (ny < 0 || ny > BMAX) m_dy = -m_dy;
            else m_by = ny;
            nx = m_bx + m_dx * m_spd;
            if ((m_dx < 0 && nx < PXL) || (m_dx > 0 && nx + BS - 1 > PXR)) begin
               if (overlaps(m_by - ((ny < 0 || ny > BMAX) ? 0 : m_dy * m_spd),
                            (m_dx < 0) ? op1 : op2)) begin
                  m_dx = -m_dx;
                  m_hit = 1;
                  n_hits++;
`ifdef PONG_SPEEDUP_EN
                  if (m_spd < MAXS) m_spd++;
`endif
               end else begin
                  scored = 1;
                  if (m_dx < 0) begin
                     m_s2++;
                     if (m_s2 == WINS) m_win = 1;
                  end else begin
                     m_s1++;
                     if (m_s1 == WINS) m_win = 0;
                  end
               end
            end else begin
               m_bx = nx;
            end
            if (scored) begin
               m_miss = 1; n_miss++;
               m_bx = CX; m_by = CY;
               if (m_s1 == WINS || m_s2 == WINS) begin
                  m_phase = 2; m_go = 1; n_over++;
               end else begin
                  m_phase = 0;
               end
            end
         end
      end
   endtask

   function automatic logic [63:0] exp_vec();
      return {8'd0, 11'(m_p1), 11'(m_p2), 11'(m_bx), 11'(m_by), 4'(m_s1), 4'(m_s2),
              1'(m_go), 1'(m_win), 1'(m_hit), 1'(m_miss)};
   endfunction

   function automatic logic [63:0] act_vec();
      return {8'd0, pdl1_y, pdl2_y, ball_x, ball_y, score1, score2,
              game_over, winner, hit, miss};
   endfunction

   task automatic step(input logic bt, input logic pt, input logic a, input logic b,
                       input logic c, input logic d, input logic ng, input logic r);
      ball_tick = bt; pdl_tick = pt; p1_up = a; p1_down = b; p2_up = c; p2_down = d;
      new_game = ng; rst = r;
      @(posedge clk);
      #1;
      model_step(bt, pt, a, b, c, d, ng, r);
   endtask

   typedef struct {
      logic bt, pt, a, b, c, d, ng;
      int   e_p1, e_p2, e_bx, e_by;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int n;
      bit got;
      logic bt, pt, ng, r;
      int over_wait;

      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 205, 210, 317, 237};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 205, 210, 317, 237};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 205, 215, 317, 237};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 205, 215, 317, 237};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 205, 215, 317, 237};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 205, 215, 316, 236};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 210, 215, 315, 235};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 210, 215, 314, 234};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 210, 215, 313, 233};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 210, 215, 312, 232};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 210, 210, 317, 237};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 210, 210, 317, 237};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 210, 210, 316, 236};
      n_hits = 0; n_miss = 0; n_over = 0;

      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("reset_state", act_vec(),
            {8'd0, 11'd210, 11'd210, 11'd317, 11'd237, 4'd0, 4'd0, 4'b0000});

      // Serve from reset goes up-left; new_game restarts serve order.
      foreach (vecs[i]) begin
         step(vecs[i].bt, vecs[i].pt, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
              vecs[i].ng, 1'b0);
         check($sformatf("vec%0d_pos", i), {8'd0, pdl1_y, pdl2_y, ball_x, ball_y},
               {8'd0, 11'(vecs[i].e_p1), 11'(vecs[i].e_p2), 11'(vecs[i].e_bx),
                11'(vecs[i].e_by)});
         check($sformatf("vec%0d_pulse", i), {hit, miss, game_over}, 3'b000);
      end

      // Paddle saturation at both ends.
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int t = 1; t <= 50; t++) begin
         step(0, 1, 1, 0, 0, 1, 0, 0);
         if (t == 41) check("pdl_t41", {pdl1_y, pdl2_y}, {11'd5, 11'd415});
         if (t == 42) check("pdl_t42", {pdl1_y, pdl2_y}, {11'd0, 11'd420});
      end
      check("pdl_t50", {pdl1_y, pdl2_y}, {11'd0, 11'd420});
      step(0, 1, 1, 1, 1, 1, 0, 0);
      check("pdl_both", {pdl1_y, pdl2_y}, {11'd0, 11'd420});

      // Left paddle at 0 catches the ball on its bottom row (ball y 59..64).
      n = 0; got = 0;
      while (!got && n < 400) begin
         step(1, 0, 0, 0, 0, 0, 0, 0);
         n++;
         if (hit || miss) got = 1;
      end
      check("hit_kind", {hit, miss}, 2'b10);
      check("hit_tick", 64'(n), 64'd299);
      check("hit_pos", {ball_x, ball_y, score1, score2}, {11'd20, 11'd60, 4'd0, 4'd0});
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("hit_len", {hit, miss}, 2'b00);

      // Left paddle parked at the bottom: player 1 misses.
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int t = 0; t < 42; t++) step(0, 1, 0, 1, 0, 0, 0, 0);
      n = 0; got = 0;
      while (!got && n < 400) begin
         step(1, 0, 0, 0, 0, 0, 0, 0);
         n++;
         if (hit || miss) got = 1;
      end
      check("miss_kind", {hit, miss}, 2'b01);
      check("miss_tick", 64'(n), 64'd299);
      check("miss_state", {ball_x, ball_y, score1, score2, game_over},
            {11'd317, 11'd237, 4'd0, 4'd1, 1'b0});
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("miss_serve_hold", {ball_x, ball_y, hit, miss}, {11'd317, 11'd237, 2'b00});

      // Randomized play against the model.
      step(0, 0, 0, 0, 0, 0, 1, 0);
      over_wait = 0;
      for (int t = 0; t < 30000; t++) begin
         bt = ($urandom_range(0, 2) != 0);
         pt = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 12000) == 0);
         ng = ($urandom_range(0, 8000) == 0);
         if (m_phase == 2) begin
            over_wait++;
            if (over_wait > 40) begin
               ng = 1;
               over_wait = 0;
            end
         end
         step(bt, pt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ng, r);
         check("rand", act_vec(), exp_vec());
      end
      $display("info: model saw hits=%0d points=%0d matches_over=%0d", n_hits, n_miss, n_over);
      check("cov_over", 64'(n_over > 0), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
